// File: rtl/apple_spawner_if.sv
// Bus between the game logic and the apple spawner.
// The game side drives the random source, the snake body and the eat events.
// The spawner side returns the apple slots and its status flags.
interface apple_spawner_if #(
    parameter int XW         = 4,
    parameter int YW         = 4,
    parameter int MAX_LEN    = 50,
    parameter int NUM_APPLES = 2
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(NUM_APPLES) | 1;

    logic [XW-1:0]               rand_x;
    logic [YW-1:0]               rand_y;
    logic [MAX_LEN*(XW+YW)-1:0]  body;
    logic [LW-1:0]               body_len;
    logic                        eat;
    logic [IW-1:0]               eat_idx;
    logic [NUM_APPLES*XW-1:0]    apple_x;
    logic [NUM_APPLES*YW-1:0]    apple_y;
    logic [NUM_APPLES-1:0]       apple_valid;
    logic                        busy;
    logic                        spawn_fail;

    modport master (
        output rand_x, rand_y, body, body_len, eat, eat_idx,
        input  apple_x, apple_y, apple_valid, busy, spawn_fail
    );

    modport slave (
        input  rand_x, rand_y, body, body_len, eat, eat_idx,
        output apple_x, apple_y, apple_valid, busy, spawn_fail
    );
endinterface

// File: rtl/apple_spawner.sv
// Multi-apple generator for the snake game.
// Keeps NUM_APPLES slots. Whenever a slot is empty it draws a random candidate.
// The candidate is checked against the grid bounds and the live apples every cycle.
// It is also checked against one snake body segment per cycle.
// A candidate that survives the whole body is placed into the lowest empty slot.
module apple_spawner #(
    parameter int GRID_W     = 16,
    parameter int GRID_H     = 16,
    parameter int XW         = 4,
    parameter int YW         = 4,
    parameter int MAX_LEN    = 50,
    parameter int NUM_APPLES = 2,
    parameter int MAX_RETRY  = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_reset,
    apple_spawner_if.slave bus
);
    localparam int SW  = XW + YW;
    localparam int LW  = $clog2(MAX_LEN + 1);
    localparam int RW  = $clog2(MAX_RETRY + 1);
    localparam int SLW = (NUM_APPLES > 1) ? $clog2(NUM_APPLES) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t                  state_q;
    logic [SLW-1:0]          slot_q;
    logic [XW-1:0]           cand_x_q;
    logic [YW-1:0]           cand_y_q;
    logic [LW-1:0]           idx_q;
    logic [RW-1:0]           retry_q;
    logic [XW-1:0]           ax_q [NUM_APPLES];
    logic [YW-1:0]           ay_q [NUM_APPLES];
    logic [NUM_APPLES-1:0]   valid_q;
    logic                    busy_q;
    logic                    fail_q;

    logic                    free_any;
    logic [SLW-1:0]          free_idx;
    logic [SW-1:0]           seg;
    logic                    hit_bounds;
    logic                    hit_apple;
    logic                    hit_body;
    logic                    reject;
    logic                    at_end;
    logic                    place;
    logic [RW-1:0]           retry_inc;
    logic                    give_up;
    logic [NUM_APPLES-1:0]   eat_mask;
    logic [NUM_APPLES-1:0]   place_mask;
    logic [NUM_APPLES-1:0]   valid_d;

    // Lowest empty slot; it is the next one to be refilled.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int unsigned s = 0; s < NUM_APPLES; s++) begin
            if (!valid_q[s] && !free_any) begin
                free_any = 1'b1;
                free_idx = SLW'(s);
            end
        end
    end

    // Candidate checks for the current scan cycle.
    // The bounds and apple checks repeat every cycle. The body check covers only segment idx_q.
    always_comb begin
        seg = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (32'(idx_q) == i) begin
                seg = bus.body[i*SW +: SW];
            end
        end

        hit_apple = 1'b0;
        for (int unsigned s = 0; s < NUM_APPLES; s++) begin
            if (valid_q[s] && ax_q[s] == cand_x_q && ay_q[s] == cand_y_q) begin
                hit_apple = 1'b1;
            end
        end

        hit_bounds = (32'(cand_x_q) >= 32'(GRID_W)) || (32'(cand_y_q) >= 32'(GRID_H));
        hit_body   = (idx_q < bus.body_len) && (seg == {cand_y_q, cand_x_q});
        reject     = (state_q == ST_SCAN) && (hit_bounds || hit_apple || hit_body);
        at_end     = (idx_q == bus.body_len);
        place      = (state_q == ST_SCAN) && !reject && at_end;
        retry_inc  = retry_q + RW'(1);
        give_up    = (retry_inc == RW'(MAX_RETRY));
    end

    // Slot occupancy after this edge: an eat clears its slot and a placement sets its slot.
    // Both can occur on different slots at the same edge.
    always_comb begin
        eat_mask   = '0;
        place_mask = '0;
        for (int unsigned s = 0; s < NUM_APPLES; s++) begin
            eat_mask[s]   = bus.eat && (32'(bus.eat_idx) == s);
            place_mask[s] = place && (32'(slot_q) == s);
        end
        valid_d = (valid_q & ~eat_mask) | place_mask;
    end

    // Spawn FSM with registered slot state and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            slot_q   <= '0;
            cand_x_q <= '0;
            cand_y_q <= '0;
            idx_q    <= '0;
            retry_q  <= '0;
            valid_q  <= '0;
            busy_q   <= 1'b0;
            fail_q   <= 1'b0;
            for (int unsigned s = 0; s < NUM_APPLES; s++) begin
                ax_q[s] <= '0;
                ay_q[s] <= '0;
            end
        end else if (s_reset) begin
            state_q  <= ST_IDLE;
            slot_q   <= '0;
            cand_x_q <= '0;
            cand_y_q <= '0;
            idx_q    <= '0;
            retry_q  <= '0;
            valid_q  <= '0;
            busy_q   <= 1'b0;
            fail_q   <= 1'b0;
            for (int unsigned s = 0; s < NUM_APPLES; s++) begin
                ax_q[s] <= '0;
                ay_q[s] <= '0;
            end
        end else begin
            fail_q  <= 1'b0;
            valid_q <= valid_d;
            for (int unsigned s = 0; s < NUM_APPLES; s++) begin
                if (place_mask[s]) begin
                    ax_q[s] <= cand_x_q;
                    ay_q[s] <= cand_y_q;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (free_any) begin
                        slot_q   <= free_idx;
                        cand_x_q <= bus.rand_x;
                        cand_y_q <= bus.rand_y;
                        idx_q    <= '0;
                        retry_q  <= '0;
                        state_q  <= ST_SCAN;
                        busy_q   <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (reject) begin
                        if (give_up) begin
                            fail_q  <= 1'b1;
                            retry_q <= '0;
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            retry_q  <= retry_inc;
                            cand_x_q <= bus.rand_x;
                            cand_y_q <= bus.rand_y;
                            idx_q    <= '0;
                        end
                    end else if (at_end) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + LW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Flatten the slot registers onto the output buses.
    for (genvar g = 0; g < NUM_APPLES; g++) begin : g_out
        assign bus.apple_x[g*XW +: XW] = ax_q[g];
        assign bus.apple_y[g*YW +: YW] = ay_q[g];
    end

    assign bus.apple_valid = valid_q;
    assign bus.busy        = busy_q;
    assign bus.spawn_fail  = fail_q;
endmodule

// File: tb/tb_apple_spawner.sv
// Directed bench for apple_spawner.
// Instance A is a 10x16 grid with one slot. Instance B is a 16x16 grid with two slots.
module tb_apple_spawner;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    logic srst_a;
    logic srst_b;
    int   total = 0;
    int   bad   = 0;
    int   fails;

    always #5 clk = ~clk;

    apple_spawner_if #(.XW(4), .YW(4), .MAX_LEN(50), .NUM_APPLES(1)) ifa ();
    apple_spawner_if #(.XW(4), .YW(4), .MAX_LEN(50), .NUM_APPLES(2)) ifb ();

    apple_spawner #(
        .GRID_W(10), .GRID_H(16), .XW(4), .YW(4),
        .MAX_LEN(50), .NUM_APPLES(1), .MAX_RETRY(8)
    ) dut_a (
        .clk(clk), .reset(rst_a), .s_reset(srst_a), .bus(ifa)
    );

    apple_spawner #(
        .GRID_W(16), .GRID_H(16), .XW(4), .YW(4),
        .MAX_LEN(50), .NUM_APPLES(2), .MAX_RETRY(8)
    ) dut_b (
        .clk(clk), .reset(rst_b), .s_reset(srst_b), .bus(ifb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; srst_a = 1'b0; srst_b = 1'b0;
        ifa.rand_x = 4'd5; ifa.rand_y = 4'd8; ifa.eat = 1'b0; ifa.eat_idx = '0;
        ifa.body = '0; ifa.body_len = 6'd4;
        ifa.body[0*8 +: 8] = {4'd7, 4'd4};
        ifa.body[1*8 +: 8] = {4'd7, 4'd3};
        ifa.body[2*8 +: 8] = {4'd7, 4'd2};
        ifa.body[3*8 +: 8] = {4'd7, 4'd1};
        ifb.rand_x = 4'd2; ifb.rand_y = 4'd3; ifb.eat = 1'b0; ifb.eat_idx = '0;
        ifb.body = '0; ifb.body_len = 6'd0;
        tick();
        tick();

        // Power-on state
        check("a_rst_valid", ifa.apple_valid, 0);
        check("a_rst_x", ifa.apple_x, 0);
        check("a_rst_y", ifa.apple_y, 0);
        check("a_rst_busy", ifa.busy, 0);
        check("a_rst_fail", ifa.spawn_fail, 0);
        check("b_rst_valid", ifb.apple_valid, 0);
        check("b_rst_x", ifb.apple_x, 0);
        check("b_rst_busy", ifb.busy, 0);

        // Clean spawn: body_len=4 gives placement at T+5
        rst_a = 1'b0;
        tick();
        check("spawn_busy_T", ifa.busy, 1);
        check("spawn_valid_T", ifa.apple_valid, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("spawn_busy_scan", ifa.busy, 1);
            check("spawn_valid_scan", ifa.apple_valid, 0);
        end
        tick();
        check("spawn_valid", ifa.apple_valid, 1);
        check("spawn_busy_done", ifa.busy, 0);
        check("spawn_x", ifa.apple_x, 5);
        check("spawn_y", ifa.apple_y, 8);

        // Body hit at segment 0, then accept (9,2)
        ifa.eat = 1'b1; ifa.eat_idx = '0; ifa.rand_x = 4'd4; ifa.rand_y = 4'd7;
        tick();
        check("eat_clear", ifa.apple_valid, 0);
        check("eat_keep_x", ifa.apple_x, 5);
        ifa.eat = 1'b0;
        tick();
        check("rej_busy", ifa.busy, 1);
        ifa.rand_x = 4'd9; ifa.rand_y = 4'd2;
        repeat (5) tick();
        check("rej_not_yet", ifa.apple_valid, 0);
        tick();
        check("rej_valid", ifa.apple_valid, 1);
        check("rej_x", ifa.apple_x, 9);
        check("rej_y", ifa.apple_y, 2);

        // Out-of-grid x=12 rejected, then accept (6,9)
        ifa.eat = 1'b1; ifa.rand_x = 4'd12; ifa.rand_y = 4'd3;
        tick();
        ifa.eat = 1'b0;
        tick();
        ifa.rand_x = 4'd6; ifa.rand_y = 4'd9;
        repeat (5) tick();
        check("oob_not_yet", ifa.apple_valid, 0);
        tick();
        check("oob_valid", ifa.apple_valid, 1);
        check("oob_x", ifa.apple_x, 6);
        check("oob_y", ifa.apple_y, 9);

        // Exhaustion: (3,7) hits segment 1 each attempt, 8 rejects in 16 cycles
        ifa.eat = 1'b1; ifa.rand_x = 4'd3; ifa.rand_y = 4'd7;
        tick();
        ifa.eat = 1'b0;
        tick();
        fails = 0;
        repeat (15) begin
            tick();
            if (ifa.spawn_fail) fails++;
        end
        check("exh_no_early_fail", fails, 0);
        check("exh_busy_before", ifa.busy, 1);
        tick();
        check("exh_fail_pulse", ifa.spawn_fail, 1);
        check("exh_busy_drop", ifa.busy, 0);
        check("exh_valid", ifa.apple_valid, 0);
        tick();
        check("exh_fail_clear", ifa.spawn_fail, 0);
        check("exh_retrigger", ifa.busy, 1);

        // Synchronous restart mid-scan
        srst_a = 1'b1;
        tick();
        check("srst_busy", ifa.busy, 0);
        check("srst_valid", ifa.apple_valid, 0);
        check("srst_x", ifa.apple_x, 0);
        check("srst_y", ifa.apple_y, 0);
        srst_a = 1'b0; ifa.rand_x = 4'd5; ifa.rand_y = 4'd8;
        tick();
        check("srst_restart_busy", ifa.busy, 1);
        repeat (4) tick();
        tick();
        check("srst_respawn_x", ifa.apple_x, 5);
        check("srst_respawn_valid", ifa.apple_valid, 1);

        // Asynchronous reset mid-scan clears before the next edge
        ifa.eat = 1'b1;
        tick();
        ifa.eat = 1'b0;
        tick();
        tick();
        check("arst_pre_busy", ifa.busy, 1);
        #2;
        rst_a = 1'b1;
        #1;
        check("arst_busy", ifa.busy, 0);
        check("arst_valid", ifa.apple_valid, 0);
        check("arst_x", ifa.apple_x, 0);
        check("arst_y", ifa.apple_y, 0);

        // Two slots on B with body_len=0
        rst_b = 1'b0;
        tick();
        check("b_busy_T", ifb.busy, 1);
        check("b_valid_T", ifb.apple_valid, 0);
        tick();
        check("b_slot0_valid", ifb.apple_valid, 2'b01);
        check("b_slot0_x", ifb.apple_x, 8'h02);
        check("b_slot0_y", ifb.apple_y, 8'h03);
        check("b_slot0_busy", ifb.busy, 0);
        tick();
        check("b_slot1_busy", ifb.busy, 1);
        ifb.rand_x = 4'd11; ifb.rand_y = 4'd12;
        tick();
        check("b_slot1_rej", ifb.apple_valid, 2'b01);
        tick();
        check("b_both_valid", ifb.apple_valid, 2'b11);
        check("b_both_x", ifb.apple_x, 8'hB2);
        check("b_both_y", ifb.apple_y, 8'hC3);

        // Eat slot 1, which then respawns at (7,1)
        ifb.eat = 1'b1; ifb.eat_idx = 1'b1; ifb.rand_x = 4'd7; ifb.rand_y = 4'd1;
        tick();
        check("b_eat1_valid", ifb.apple_valid, 2'b01);
        check("b_eat1_keep_x", ifb.apple_x, 8'hB2);
        ifb.eat = 1'b0;
        tick();
        check("b_resp_busy", ifb.busy, 1);
        tick();
        check("b_resp_valid", ifb.apple_valid, 2'b11);
        check("b_resp_x", ifb.apple_x, 8'h72);
        check("b_resp_y", ifb.apple_y, 8'h13);

        // Eat slot 0, then eat it again while empty, then place slot 0 and eat slot 1 on the same edge
        ifb.eat = 1'b1; ifb.eat_idx = 1'b0; ifb.rand_x = 4'd0; ifb.rand_y = 4'd0;
        tick();
        check("b_eat0_valid", ifb.apple_valid, 2'b10);
        tick();
        check("b_eat_empty", ifb.apple_valid, 2'b10);
        check("b_eat_empty_busy", ifb.busy, 1);
        ifb.eat_idx = 1'b1;
        tick();
        check("b_mixed_valid", ifb.apple_valid, 2'b01);
        check("b_mixed_x", ifb.apple_x, 8'h70);
        check("b_mixed_y", ifb.apple_y, 8'h10);
        ifb.eat = 1'b0;
        tick();
        check("b_mixed_respawn", ifb.busy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
